ft245_frame_tx: RTL and testbench

- Transmit-side frame builder for the FT245 host link; the counterpart of the existing host-command frame parser.
- Packs one response frame per request and streams it byte-by-byte into the FT245RL core's TX handshake: SOF 0xFE, command byte, 4 payload bytes LSB first, XOR checksum.
- Sits between the control FSMs (ADC, ADF PLL, status) and FT245RL.
- Lets the FPGA acknowledge commands and report status using the same framing the host already sends.

---
 rtl/ft245_frame_tx_pkg.sv | 19 +
 rtl/ft245_frame_tx_if.sv | 12 +
 rtl/ft245_frame_tx.sv | 140 ++++++++++++++
 tb/tb_ft245_frame_tx.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ft245_frame_tx_pkg.sv
// Shared FT245 host-link framing constants, used by both the TX frame
// builder and the RX command parser.
package ft245_frame_tx_pkg;

  localparam logic [7:0] SOF = 8'hFE;

  localparam logic [3:0] CMD_START_ADC    = 4'd1;
  localparam logic [3:0] CMD_POLL_STATUS  = 4'd2;
  localparam logic [3:0] CMD_SET_ADF_FREQ = 4'd3;
  localparam logic [3:0] CMD_SAMPLING_CLK = 4'd4;

  localparam int         FRAME_LEN = 7;
  localparam logic [2:0] LAST_IDX  = 3'(FRAME_LEN - 1);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WAIT_RDY  = 2'd1;
  localparam logic [1:0] ST_WAIT_DONE = 2'd2;

endpackage

// File: rtl/ft245_frame_tx_if.sv
// Byte handshake between the frame builder (master) and the FT245RL core.
// TX_EN strobes TX_DATA for one cycle, only issued while TX_VALID (busy) is
// low; the core answers each byte with a one-cycle TX_DONE.
interface ft245_frame_tx_if;
  logic       TX_EN;
  logic [7:0] TX_DATA;
  logic       TX_VALID;
  logic       TX_DONE;

  modport master (output TX_EN, output TX_DATA, input TX_VALID, input TX_DONE);
  modport slave  (input TX_EN, input TX_DATA, output TX_VALID, output TX_DONE);
endinterface

// File: rtl/ft245_frame_tx.sv
// Builds one 7-byte response frame (SOF, CMD, 4 payload bytes LSB first,
// XOR checksum) per request and streams it into the FT245RL TX handshake.
module ft245_frame_tx
  import ft245_frame_tx_pkg::*;
#(
  parameter logic [7:0]  SOF_BYTE       = SOF,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               FRAME_START,
  input  logic [3:0]         FRAME_CMD,
  input  logic [31:0]        FRAME_PAYLOAD,
  output logic               BUSY,
  output logic               FRAME_DONE,
  output logic               FRAME_ERR,
  output logic [1:0]         DBG_STATE,
  ft245_frame_tx_if.master   tx
);

  logic [1:0]  state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  ck_q, ck_d;
  logic [3:0]  cmd_q, cmd_d;
  logic [31:0] pay_q, pay_d;
  logic [15:0] cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        tx_en_q, tx_en_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic [7:0]  cur_byte;

  always_comb begin
    case (idx_q)
      3'd0:    cur_byte = SOF_BYTE;
      3'd1:    cur_byte = {4'h0, cmd_q};
      3'd2:    cur_byte = pay_q[7:0];
      3'd3:    cur_byte = pay_q[15:8];
      3'd4:    cur_byte = pay_q[23:16];
      3'd5:    cur_byte = pay_q[31:24];
      default: cur_byte = ck_q;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    ck_d      = ck_q;
    cmd_d     = cmd_q;
    pay_d     = pay_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    tx_en_d   = 1'b0;
    tx_data_d = tx_data_q;
    case (state_q)
      ST_IDLE: begin
        // The completion cycle is still IDLE, but a request there must not start a frame.
        if (FRAME_START && !done_q && !err_q) begin
          cmd_d   = FRAME_CMD;
          pay_d   = FRAME_PAYLOAD;
          idx_d   = 3'd0;
          ck_d    = 8'h00;
          busy_d  = 1'b1;
          state_d = ST_WAIT_RDY;
        end
      end
      ST_WAIT_RDY: begin
        if (!tx.TX_VALID) begin
          tx_data_d = cur_byte;
          tx_en_d   = 1'b1;
          if (idx_q >= 3'd1 && idx_q <= 3'd5) ck_d = ck_q ^ cur_byte;
          cnt_d     = 16'd0;
          state_d   = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        // TX_DONE takes priority over a timeout expiring in the same cycle.
        if (tx.TX_DONE) begin
          if (idx_q == LAST_IDX) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = ST_WAIT_RDY;
          end
        end else if (TIMEOUT_CYCLES != 16'd0 && cnt_q == TIMEOUT_CYCLES - 16'd1) begin
          err_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      idx_q     <= 3'd0;
      ck_q      <= 8'h00;
      cmd_q     <= 4'h0;
      pay_q     <= 32'h0;
      cnt_q     <= 16'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      tx_en_q   <= 1'b0;
      tx_data_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      ck_q      <= ck_d;
      cmd_q     <= cmd_d;
      pay_q     <= pay_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      tx_en_q   <= tx_en_d;
      tx_data_q <= tx_data_d;
    end
  end

  assign BUSY       = busy_q;
  assign FRAME_DONE = done_q;
  assign FRAME_ERR  = err_q;
  assign DBG_STATE  = state_q;
  assign tx.TX_EN   = tx_en_q;
  assign tx.TX_DATA = tx_data_q;

endmodule

// File: tb/tb_ft245_frame_tx.sv
// Randomized scoreboard bench for ft245_frame_tx: a responder plays the
// FT245RL core, a monitor checks every strobed byte and frame completion.
module tb_ft245_frame_tx;

  localparam logic [15:0] TO_CYC = 16'd16;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_start;
  logic [3:0]  frame_cmd;
  logic [31:0] frame_payload;
  logic        busy, frame_done, frame_err;
  logic [1:0]  dbg_state;

  ft245_frame_tx_if tx_bus ();

  ft245_frame_tx #(.SOF_BYTE(8'hFE), .TIMEOUT_CYCLES(TO_CYC)) dut (
    .CLK(clk), .RST(rst), .FRAME_START(frame_start), .FRAME_CMD(frame_cmd),
    .FRAME_PAYLOAD(frame_payload), .BUSY(busy), .FRAME_DONE(frame_done),
    .FRAME_ERR(frame_err), .DBG_STATE(dbg_state), .tx(tx_bus)
  );

  // ---------------- clock / reset bookkeeping ----------------
  always #5 clk = ~clk;

  int   cyc = 0;
  logic valid_at_edge = 1'b0;
  always @(posedge clk) begin
    cyc           <= cyc + 1;
    valid_at_edge <= tx_bus.TX_VALID;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d required=<200000", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [7:0] exp_q[$];
  logic [1:0] evt_q[$];          // 1 = FRAME_DONE, 2 = FRAME_ERR
  int checks = 0;
  int errors = 0;

  int rsp_idx       = 0;
  int withhold_at   = -1;
  int fixed_delay   = 3;
  int start_cyc     = 0;
  int last_done_cyc = 0;
  int last_en_cyc   = 0;
  bit first_pending = 1'b0;
  bit skip_gap      = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h (cyc %0d)", name, act, req, cyc);
    end
  endtask

  // Reference frame: SOF, command, payload LSB first, XOR of bytes 1..5.
  task automatic push_frame(input logic [3:0] cmd, input logic [31:0] p,
                            input int n_sent, input logic [1:0] evt);
    logic [7:0] b[7];
    b[0] = 8'hFE;
    b[1] = {4'h0, cmd};
    for (int i = 0; i < 4; i++) b[2+i] = p[8*i +: 8];
    b[6] = 8'h00;
    for (int i = 1; i <= 5; i++) b[6] = b[6] ^ b[i];
    for (int i = 0; i < n_sent; i++) exp_q.push_back(b[i]);
    if (evt != 2'd0) evt_q.push_back(evt);
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_frame(input logic [3:0] cmd, input logic [31:0] p,
                            input int n_sent, input logic [1:0] evt);
    push_frame(cmd, p, n_sent, evt);
    @(negedge clk);
    frame_cmd     = cmd;
    frame_payload = p;
    frame_start   = 1'b1;
    rsp_idx       = 0;
    first_pending = 1'b1;
    start_cyc     = cyc;
    @(negedge clk);
    frame_start   = 1'b0;
    frame_cmd     = 4'($urandom);
    frame_payload = $urandom;
  endtask

  task automatic wait_bytes(input int n);
    for (int i = 0; i < 500; i++) begin
      if (rsp_idx >= n) return;
      @(negedge clk);
    end
    chk("wait_bytes_timeout", 32'(rsp_idx), 32'(n));
  endtask

  task automatic wait_frame_end();
    bit got = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (frame_done || frame_err) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) chk("frame_end_timeout", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  // ---------------- FT245RL responder ----------------
  initial begin
    int idx;
    int d;
    tx_bus.TX_DONE = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_bus.TX_EN) begin
        idx = rsp_idx;
        rsp_idx++;
        if (idx != withhold_at) begin
          d = (fixed_delay != 0) ? fixed_delay : int'($urandom_range(1, 10));
          repeat (d) @(negedge clk);
          tx_bus.TX_DONE = 1'b1;
          last_done_cyc  = cyc;
          @(negedge clk);
          tx_bus.TX_DONE = 1'b0;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (tx_bus.TX_EN) begin
        if (exp_q.size() == 0) chk("tx_unexpected_byte", {24'h0, tx_bus.TX_DATA}, 32'hFFFF_FFFF);
        else chk("tx_data", {24'h0, tx_bus.TX_DATA}, {24'h0, exp_q.pop_front()});
        chk("tx_en_while_valid", {31'h0, valid_at_edge}, 32'd0);
        if (first_pending) begin
          chk("first_tx_en_latency", 32'(cyc - start_cyc), 32'd2);
          first_pending = 1'b0;
        end else begin
          if (!skip_gap) chk("byte_gap_latency", 32'(cyc - last_done_cyc), 32'd2);
          skip_gap = 1'b0;
        end
        last_en_cyc = cyc;
      end
      if (frame_done || frame_err) begin
        if (evt_q.size() == 0) chk("unexpected_frame_event", {30'h0, frame_err, frame_done}, 32'd0);
        else chk("frame_event", {30'h0, frame_err, frame_done}, {30'h0, evt_q.pop_front()});
        chk("busy_at_frame_end", {31'h0, busy}, 32'd0);
        if (frame_done) chk("done_latency", 32'(cyc - last_done_cyc), 32'd1);
        if (frame_err)  chk("err_timeout_cycles", 32'(cyc - last_en_cyc), 32'(TO_CYC));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bit done_seen;
    rst             = 1'b1;
    frame_start     = 1'b0;
    frame_cmd       = 4'h0;
    frame_payload   = 32'h0;
    tx_bus.TX_VALID = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", {31'h0, busy}, 32'd0);
    chk("rst_frame_done", {31'h0, frame_done}, 32'd0);
    chk("rst_frame_err", {31'h0, frame_err}, 32'd0);
    chk("rst_tx_en", {31'h0, tx_bus.TX_EN}, 32'd0);
    chk("rst_tx_data", {24'h0, tx_bus.TX_DATA}, 32'd0);
    chk("rst_state", {30'h0, dbg_state}, 32'd0);

    // Basic frame, fixed 3-cycle TX_DONE turnaround.
    fixed_delay = 3;
    send_frame(4'd3, 32'h000F_4240, 7, 2'd1);
    wait_frame_end();

    // Stall before byte 2 for 20 cycles.
    send_frame(4'd1, 32'h0, 7, 2'd1);
    wait_bytes(2);
    @(negedge clk);
    tx_bus.TX_VALID = 1'b1;
    skip_gap        = 1'b1;
    repeat (20) @(negedge clk);
    chk("no_tx_en_in_stall", 32'(rsp_idx), 32'd2);
    tx_bus.TX_VALID = 1'b0;
    wait_frame_end();

    // A second request mid-frame is dropped; BUSY holds until FRAME_DONE.
    send_frame(4'd1, $urandom, 7, 2'd1);
    wait_bytes(3);
    @(negedge clk);
    frame_cmd   = 4'd2;
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    done_seen   = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (frame_done) begin
        done_seen = 1'b1;
        break;
      end
      chk("busy_mid_frame", {31'h0, busy}, 32'd1);
    end
    if (!done_seen) chk("busy_test_timeout", 32'd0, 32'd1);
    @(negedge clk);

    // Byte 3's TX_DONE withheld: timeout, then a clean frame from SOF.
    withhold_at = 3;
    send_frame(4'($urandom), $urandom, 4, 2'd2);
    wait_frame_end();
    withhold_at = -1;
    send_frame(4'd2, $urandom, 7, 2'd1);
    wait_frame_end();

    // Reset right after byte 4 is strobed.
    send_frame(4'd3, $urandom, 5, 2'd0);
    wait_bytes(5);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", {31'h0, busy}, 32'd0);
    chk("midrst_tx_en", {31'h0, tx_bus.TX_EN}, 32'd0);
    chk("midrst_tx_data", {24'h0, tx_bus.TX_DATA}, 32'd0);
    chk("midrst_done_err", {30'h0, frame_err, frame_done}, 32'd0);
    chk("midrst_state", {30'h0, dbg_state}, 32'd0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    send_frame(4'd4, 32'h0000_0003, 7, 2'd1);
    wait_frame_end();

    // Randomized frames with random TX_DONE turnaround.
    fixed_delay = 0;
    for (int f = 0; f < 8; f++) begin
      send_frame(4'($urandom_range(0, 15)), $urandom, 7, 2'd1);
      wait_frame_end();
      repeat ($urandom_range(0, 4)) @(negedge clk);
    end

    repeat (20) @(negedge clk);
    chk("bytes_left_in_queue", 32'(exp_q.size()), 32'd0);
    chk("events_left_in_queue", 32'(evt_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
